// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for a 16-bit processor datapath.
// Sequences fetch / decode / execute / memory / writeback from the latched
// OPCODE and FUNCFIELD fields and drives every datapath control strobe.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   OPCODE, FUNCFIELD instruction register bits [15:12] and [3:0]
//   D_MemReady        unified memory read-valid / write-accepted handshake
//   C_*               datapath control strobes (combinational from state)
//   ILLEGAL           sticky undefined-instruction flag
//   STATE             current state encoding for debug
module multicycle_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OPCODE,
  input  logic [3:0] FUNCFIELD,
  input  logic       D_MemReady,
  output logic       C_IRWrite,
  output logic       C_PCWrite,
  output logic       C_PCWriteCond,
  output logic       C_BranchNE,
  output logic [1:0] C_PCSource,
  output logic       C_IorD,
  output logic       C_MemRead,
  output logic       C_MemWrite,
  output logic       C_MemtoReg,
  output logic       C_RegWrite,
  output logic       C_ALUSrcA,
  output logic [1:0] C_ALUSrcB,
  output logic [2:0] C_ALUOp,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [3:0] OP_SHIFT   = 4'b0000;
  localparam logic [3:0] OP_LW      = 4'b0001;
  localparam logic [3:0] OP_SW      = 4'b0010;
  localparam logic [3:0] OP_JMP     = 4'b0011;
  localparam logic [3:0] OP_BE      = 4'b0100;
  localparam logic [3:0] OP_BNE     = 4'b0101;
  localparam logic [3:0] OP_LORIM   = 4'b0110;
  localparam logic [3:0] OP_LNANDIM = 4'b0111;
  localparam logic [3:0] OP_ADD     = 4'b1000;
  localparam logic [3:0] OP_ADDIMEX = 4'b1001;
  localparam logic [3:0] OP_ADDIMZ  = 4'b1010;
  localparam logic [3:0] OP_LNANDR  = 4'b1011;
  localparam logic [3:0] OP_SUB     = 4'b1100;
  localparam logic [3:0] OP_SUBIMEX = 4'b1101;
  localparam logic [3:0] OP_SUBIMZ  = 4'b1110;
  localparam logic [3:0] OP_LORR    = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_NAND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SHL  = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SHR  = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_SAR  = 3'b110;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   shift_legal;
  logic [ALUOP_W-1:0] alu_op;

  // Only shl/shr/sar are defined under the shift opcode.
  assign shift_legal = (FUNCFIELD == 4'b0001) || (FUNCFIELD == 4'b0010) ||
                       (FUNCFIELD == 4'b0011);

  // ALU function for the execute states.
  always_comb begin
    alu_op = ALU_ADD;
    unique case (OPCODE)
      OP_ADD, OP_ADDIMEX, OP_ADDIMZ:  alu_op = ALU_ADD;
      OP_SUB, OP_SUBIMEX, OP_SUBIMZ:  alu_op = ALU_SUB;
      OP_LNANDR, OP_LNANDIM:          alu_op = ALU_NAND;
      OP_LORR, OP_LORIM:              alu_op = ALU_OR;
      OP_SHIFT: begin
        case (FUNCFIELD)
          4'b0001: alu_op = ALU_SHL;
          4'b0010: alu_op = ALU_SHR;
          4'b0011: alu_op = ALU_SAR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  // State and sticky illegal flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (D_MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (OPCODE)
          OP_SHIFT: begin
            if (shift_legal) begin
              state_d = S_EXEC_R;
            end else begin
              // Undefined funct retires as a NOP; execution continues.
              state_d = S_FETCH;
              if (ILLEGAL_TRAP) illegal_d = 1'b1;
            end
          end
          OP_ADD, OP_SUB, OP_LNANDR, OP_LORR:        state_d = S_EXEC_R;
          OP_ADDIMEX, OP_ADDIMZ, OP_SUBIMEX,
          OP_SUBIMZ, OP_LNANDIM, OP_LORIM:           state_d = S_EXEC_I;
          OP_LW, OP_SW:                              state_d = S_MEM_ADDR;
          OP_BE, OP_BNE:                             state_d = S_BRANCH;
          OP_JMP:                                    state_d = S_JUMP;
          default:                                   state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (D_MemReady) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (D_MemReady) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    C_IRWrite     = 1'b0;
    C_PCWrite     = 1'b0;
    C_PCWriteCond = 1'b0;
    C_BranchNE    = 1'b0;
    C_PCSource    = 2'b00;
    C_IorD        = 1'b0;
    C_MemRead     = 1'b0;
    C_MemWrite    = 1'b0;
    C_MemtoReg    = 1'b0;
    C_RegWrite    = 1'b0;
    C_ALUSrcA     = 1'b0;
    C_ALUSrcB     = 2'b00;
    C_ALUOp       = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        // PC+1 and IR load commit only when the memory returns the word.
        C_MemRead = 1'b1;
        C_ALUSrcB = 2'b01;
        C_IRWrite = D_MemReady;
        C_PCWrite = D_MemReady;
      end
      S_DECODE: C_ALUSrcB = 2'b10;
      S_EXEC_R: begin
        C_ALUSrcA = 1'b1;
        C_ALUOp   = alu_op;
      end
      S_EXEC_I: begin
        C_ALUSrcA = 1'b1;
        C_ALUSrcB = ((OPCODE == OP_ADDIMEX) || (OPCODE == OP_SUBIMEX)) ? 2'b10 : 2'b11;
        C_ALUOp   = alu_op;
      end
      S_ALU_WB: C_RegWrite = 1'b1;
      S_MEM_ADDR: begin
        C_ALUSrcA = 1'b1;
        C_ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        C_MemRead = 1'b1;
        C_IorD    = 1'b1;
      end
      S_MEM_WB: begin
        C_RegWrite = 1'b1;
        C_MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        C_MemWrite = 1'b1;
        C_IorD     = 1'b1;
      end
      S_BRANCH: begin
        C_ALUSrcA     = 1'b1;
        C_ALUOp       = ALU_SUB;
        C_PCWriteCond = 1'b1;
        C_PCSource    = 2'b01;
        C_BranchNE    = OPCODE[0];
      end
      S_JUMP: begin
        C_PCWrite  = 1'b1;
        C_PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign ILLEGAL = illegal_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios plus
// randomized instruction streams checked against an instruction-level model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] OPCODE, FUNCFIELD;
  logic       D_MemReady;
  logic       C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE;
  logic [1:0] C_PCSource;
  logic       C_IorD, C_MemRead, C_MemWrite, C_MemtoReg, C_RegWrite, C_ALUSrcA;
  logic [1:0] C_ALUSrcB;
  logic [2:0] C_ALUOp;
  logic       ILLEGAL;
  logic [3:0] STATE;

  int checks = 0;
  int errors = 0;
  bit illegal_exp = 1'b0;

  typedef struct {
    int st;
    bit rdy;
    bit need_op;
  } step_t;

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .OPCODE(OPCODE), .FUNCFIELD(FUNCFIELD),
    .D_MemReady(D_MemReady), .C_IRWrite(C_IRWrite), .C_PCWrite(C_PCWrite),
    .C_PCWriteCond(C_PCWriteCond), .C_BranchNE(C_BranchNE),
    .C_PCSource(C_PCSource), .C_IorD(C_IorD), .C_MemRead(C_MemRead),
    .C_MemWrite(C_MemWrite), .C_MemtoReg(C_MemtoReg), .C_RegWrite(C_RegWrite),
    .C_ALUSrcA(C_ALUSrcA), .C_ALUSrcB(C_ALUSrcB), .C_ALUOp(C_ALUOp),
    .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  always #5 clk = ~clk;

  logic [16:0] ctrl_w;
  assign ctrl_w = {C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE, C_PCSource,
                   C_IorD, C_MemRead, C_MemWrite, C_MemtoReg, C_RegWrite,
                   C_ALUSrcA, C_ALUSrcB, C_ALUOp};

  // ALU function by instruction mnemonic.
  function automatic logic [2:0] exp_alu(input logic [3:0] op, input logic [3:0] fn);
    case (op)
      4'd8, 4'd9, 4'd10:  return 3'b000;   // add, addimex, addimz
      4'd12, 4'd13, 4'd14: return 3'b001;  // sub, subimex, subimz
      4'd11, 4'd7:        return 3'b010;   // lnandr, lnandim
      4'd15, 4'd6:        return 3'b011;   // lorr, lorim
      4'd0: begin
        if (fn == 4'd1) return 3'b100;
        if (fn == 4'd2) return 3'b101;
        if (fn == 4'd3) return 3'b110;
        return 3'b000;
      end
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for a phase of an instruction.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [3:0] op,
                                           input logic [3:0] fn, input bit rdy);
    logic irw, pcw, pcc, bne, iord, mr, mw, m2r, rw, asa;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {irw, pcw, pcc, bne, iord, mr, mw, m2r, rw, asa} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'b000;
    case (st)
      1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b10;
      3:  begin asa = 1; aop = exp_alu(op, fn); end
      4:  begin asa = 1; asb = (op == 4'd9 || op == 4'd13) ? 2'b10 : 2'b11; aop = exp_alu(op, fn); end
      5:  rw = 1;
      6:  begin asa = 1; asb = 2'b10; end
      7:  begin mr = 1; iord = 1; end
      8:  begin rw = 1; m2r = 1; end
      9:  begin mw = 1; iord = 1; end
      10: begin asa = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; bne = op[0]; end
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {irw, pcw, pcc, bne, pcs, iord, mr, mw, m2r, rw, asa, asb, aop};
  endfunction

  // Runs one instruction starting in FETCH; the phase list is derived from
  // the instruction class and the requested memory stalls.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn,
                           input int fstall, input int mstall, input string tag);
    step_t q[$];
    bit ill;
    ill = (op == 4'd0) && !(fn == 4'd1 || fn == 4'd2 || fn == 4'd3);
    for (int i = 0; i < fstall; i++) q.push_back('{1, 1'b0, 1'b0});
    q.push_back('{1, 1'b1, 1'b0});
    q.push_back('{2, 1'($urandom), 1'b1});
    if (!ill) begin
      case (op)
        4'd0, 4'd8, 4'd12, 4'd11, 4'd15: begin
          q.push_back('{3, 1'($urandom), 1'b1}); q.push_back('{5, 1'($urandom), 1'b0});
        end
        4'd9, 4'd10, 4'd13, 4'd14, 4'd7, 4'd6: begin
          q.push_back('{4, 1'($urandom), 1'b1}); q.push_back('{5, 1'($urandom), 1'b0});
        end
        4'd1: begin
          q.push_back('{6, 1'($urandom), 1'b1});
          for (int i = 0; i < mstall; i++) q.push_back('{7, 1'b0, 1'b0});
          q.push_back('{7, 1'b1, 1'b0});
          q.push_back('{8, 1'($urandom), 1'b0});
        end
        4'd2: begin
          q.push_back('{6, 1'($urandom), 1'b1});
          for (int i = 0; i < mstall; i++) q.push_back('{9, 1'b0, 1'b0});
          q.push_back('{9, 1'b1, 1'b0});
        end
        4'd4, 4'd5: q.push_back('{10, 1'($urandom), 1'b1});
        default:    q.push_back('{11, 1'($urandom), 1'b0});
      endcase
    end
    foreach (q[k]) begin
      logic [16:0] want;
      @(negedge clk);
      D_MemReady = q[k].rdy;
      if (q[k].need_op) begin
        OPCODE = op; FUNCFIELD = fn;
      end else begin
        OPCODE = 4'($urandom); FUNCFIELD = 4'($urandom);
      end
      #1;
      want = exp_ctrl(q[k].st, op, fn, q[k].rdy);
      checks++;
      if (STATE !== 4'(q[k].st)) begin
        errors++;
        $display("FAIL %s step%0d state: got %0d want %0d", tag, k, STATE, q[k].st);
      end
      checks++;
      if (ctrl_w !== want) begin
        errors++;
        $display("FAIL %s step%0d ctrl: got %b want %b", tag, k, ctrl_w, want);
      end
      checks++;
      if (ILLEGAL !== illegal_exp) begin
        errors++;
        $display("FAIL %s step%0d illegal: got %b want %b", tag, k, ILLEGAL, illegal_exp);
      end
      if (q[k].st == 2 && ill) illegal_exp = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; D_MemReady = 1'b1; OPCODE = 4'd8; FUNCFIELD = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (STATE !== 4'd0 || ctrl_w !== 17'd0 || ILLEGAL !== 1'b0) begin
      errors++;
      $display("FAIL reset: got state %0d ctrl %b ill %b want 0 0 0", STATE, ctrl_w, ILLEGAL);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (STATE !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: got state %0d want 0", STATE);
    end
  endtask

  task automatic test_add();
    run_instr(4'b1000, 4'b1000, 0, 0, "add");
  endtask

  task automatic test_fetch_stall();
    run_instr(4'b1100, 4'b0000, 5, 0, "fetch_stall");
  endtask

  task automatic test_lw_stall();
    run_instr(4'b0001, 4'b1001, 0, 3, "lw");
    run_instr(4'b0010, 4'b0110, 1, 2, "sw");
  endtask

  task automatic test_branch_jump();
    run_instr(4'b0101, 4'b0011, 0, 0, "bne");
    run_instr(4'b0100, 4'b1100, 0, 0, "be");
    run_instr(4'b0011, 4'b0101, 0, 0, "jmp");
  endtask

  task automatic test_shift_illegal();
    run_instr(4'b0000, 4'b0001, 0, 0, "shl");
    run_instr(4'b0000, 4'b0010, 0, 0, "shr");
    run_instr(4'b0000, 4'b0011, 0, 0, "sar");
    run_instr(4'b0000, 4'b0100, 0, 0, "illegal");
    run_instr(4'b1001, 4'b1111, 0, 0, "after_illegal");
    run_instr(4'b0110, 4'b0000, 1, 0, "lorim_sticky");
  endtask

  task automatic test_reset_mid_memwr();
    @(negedge clk); D_MemReady = 1'b1; OPCODE = 4'd2; FUNCFIELD = 4'd0;
    @(negedge clk); D_MemReady = 1'b0;
    @(negedge clk); D_MemReady = 1'b0;
    @(negedge clk); D_MemReady = 1'b0;
    #1;
    checks++;
    if (STATE !== 4'd9 || C_MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_wait: got state %0d memwrite %b want 9 1", STATE, C_MemWrite);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (STATE !== 4'd0 || C_MemWrite !== 1'b0 || ctrl_w !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got state %0d ctrl %b want 0 0", STATE, ctrl_w);
    end
    illegal_exp = 1'b0;
    checks++;
    if (ILLEGAL !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got %b want 0", ILLEGAL);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (STATE !== 4'd1) begin
      errors++;
      $display("FAIL resume_fetch: got state %0d want 1", STATE);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [3:0] op, fn;
      op = 4'($urandom_range(0, 15));
      fn = 4'($urandom);
      if (op == 4'd0 && ($urandom % 4) != 0) fn = 4'($urandom_range(1, 3));
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_fetch_stall();
    test_lw_stall();
    test_branch_jump();
    test_shift_illegal();
    test_reset_mid_memwr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
